// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round indices, state type, FSM states, S-box and GF(2^8) helpers.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_e;

    localparam logic [3:0] ROUND_INIT = 4'd0, ROUND_1 = 4'd1, ROUND_2 = 4'd2, ROUND_3 = 4'd3;
    localparam logic [3:0] ROUND_4 = 4'd4, ROUND_5 = 4'd5, ROUND_6 = 4'd6, ROUND_7 = 4'd7;
    localparam logic [3:0] ROUND_8 = 4'd8, ROUND_9 = 4'd9, ROUND_10 = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey. Purely combinational.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       final_round,
    output aes_state_t next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];

    // Byte i lives at [127-8i -: 8], row i%4, column i/4.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign sb[i] = sbox(state[127-8*i -: 8]);
        assign sr[i] = sb[(((i/4) + (i%4)) % 4) * 4 + (i%4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m [4];
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];
        assign m[0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign m[1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign m[2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign m[3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign next_state[127-8*(4*c+r) -: 8] =
                (final_round ? sr[4*c+r] : m[r]) ^ round_key[127-8*(4*c+r) -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_engine.sv
// Iterative AES-128 encryptor, one round per cycle, round keys read from the key memory.
// Optional AES_BLOCK_COUNT_EN adds a saturating delivered-block counter (blk_count_out).
module aes_cipher_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         key_init_in,
    input  logic         key_expanded_in,
    input  logic [127:0] round_key_in,
    output logic [3:0]   round_rd_out,
    input  logic [127:0] pt_in,
    input  logic         pt_valid_in,
    output logic         pt_ready_out,
    output logic [127:0] ct_out,
    output logic         ct_valid_out,
    input  logic         ct_ready_in
`ifdef AES_BLOCK_COUNT_EN
    ,
    output logic [31:0]  blk_count_out
`endif
);

    aes_fsm_e   fsm;
    logic       key_valid;
    logic [3:0] round;
    aes_state_t state_reg;
    aes_state_t round_out;

    // Round counter is held at ROUND_INIT outside ROUND, so it doubles as the read index.
    assign round_rd_out = round;
    assign pt_ready_out = (fsm == IDLE) && key_valid && !key_init_in;

    aes_round u_round (
        .state       (state_reg),
        .round_key   (round_key_in),
        .final_round (round == 4'(NUM_ROUNDS)),
        .next_state  (round_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fsm          <= IDLE;
            key_valid    <= 1'b0;
            round        <= ROUND_INIT;
            state_reg    <= '0;
            ct_out       <= '0;
            ct_valid_out <= 1'b0;
        end else begin
            if (key_init_in)          key_valid <= 1'b0;
            else if (key_expanded_in) key_valid <= 1'b1;

            case (fsm)
                IDLE: begin
                    if (pt_valid_in && pt_ready_out) begin
                        state_reg <= pt_in ^ round_key_in;
                        round     <= ROUND_1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    if (key_init_in) begin
                        // Keys are being rewritten under us; the block cannot finish.
                        round <= ROUND_INIT;
                        fsm   <= IDLE;
                    end else if (round == 4'(NUM_ROUNDS)) begin
                        ct_out       <= round_out;
                        ct_valid_out <= 1'b1;
                        round        <= ROUND_INIT;
                        fsm          <= DONE;
                    end else begin
                        state_reg <= round_out;
                        round     <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (ct_ready_in) begin
                        ct_valid_out <= 1'b0;
                        fsm          <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef AES_BLOCK_COUNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in)
            blk_count_out <= '0;
        else if (ct_valid_out && ct_ready_in && (blk_count_out != 32'hFFFF_FFFF))
            blk_count_out <= blk_count_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_aes_cipher_engine.sv
// Self-checking bench: acts as the key memory and compares against a table-driven AES-128 model.
module tb_aes_cipher_engine;

    logic         clk_in = 1'b0;
    logic         rst_in, key_init_in, key_expanded_in;
    logic [127:0] round_key_in;
    logic [3:0]   round_rd_out;
    logic [127:0] pt_in;
    logic         pt_valid_in, pt_ready_out;
    logic [127:0] ct_out;
    logic         ct_valid_out, ct_ready_in;
`ifdef AES_BLOCK_COUNT_EN
    logic [31:0]  blk_count_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] rk [11];

    always #5 clk_in = ~clk_in;

    assign round_key_in = (round_rd_out <= 4'd10) ? rk[round_rd_out] : 128'h0;

    aes_cipher_engine dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .key_init_in     (key_init_in),
        .key_expanded_in (key_expanded_in),
        .round_key_in    (round_key_in),
        .round_rd_out    (round_rd_out),
        .pt_in           (pt_in),
        .pt_valid_in     (pt_valid_in),
        .pt_ready_out    (pt_ready_out),
        .ct_out          (ct_out),
        .ct_valid_out    (ct_valid_out),
        .ct_ready_in     (ct_ready_in)
`ifdef AES_BLOCK_COUNT_EN
        ,
        .blk_count_out   (blk_count_out)
`endif
    );

    localparam logic [127:0] SROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sbt(input logic [7:0] x);
        return SROW[x[7:4]][127-8*x[3:0] -: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] a2;
        a2 = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        if (k == 1) return a;
        if (k == 2) return a2;
        return a2 ^ a;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbt(t[31:24]), sbt(t[23:16]), sbt(t[15:8]), sbt(t[7:0])} ^ {rcon[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        int coef [4] = '{2, 3, 1, 1};
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt(s[i]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int w = 0; w < 4; w++) begin
                        t[4*c+w] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            t[4*c+w] = t[4*c+w] ^ gmul(s[4*c+k], coef[(k - w + 4) % 4]);
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_key(input logic [127:0] key);
        expand_key(key);
        key_init_in = 1'b1;
        tick();
        key_init_in = 1'b0;
        repeat (2) tick();
        key_expanded_in = 1'b1;
        tick();
        key_expanded_in = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Waits (bounded) for pt_ready_out, then lets the accepting edge pass.
    task automatic send(input logic [127:0] pt, input string tag, output logic ok);
        int n = 0;
        pt_in       = pt;
        pt_valid_in = 1'b1;
        while (!pt_ready_out && n < 50) begin tick(); n++; end
        ok = pt_ready_out;
        if (!ok) chk({tag, "_accept"}, 128'(pt_ready_out), 128'(1));
        else tick();
        pt_valid_in = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] pt, input int hold, input logic kinit, input string tag);
        logic [3:0]  rds [11];
        logic [43:0] seq_got, seq_exp;
        logic [127:0] exp, ct0;
        logic bad, ok;
        int n;
        exp = ref_enc(pt);
        pt_in = pt;
        rds[0] = round_rd_out;
        send(pt, tag, ok);
        if (!ok) return;
        n = 0;
        while (!ct_valid_out && n < 40) begin
            if (n < 10) rds[n+1] = round_rd_out;
            tick();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(10));
        for (int i = 0; i < 11; i++) begin
            seq_got[4*i +: 4] = rds[i];
            seq_exp[4*i +: 4] = 4'(i);
        end
        chk({tag, "_rd_seq"}, 128'(seq_got), 128'(seq_exp));
        chk({tag, "_ct"}, ct_out, exp);
        ct0 = ct_out;
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            key_init_in = kinit && (h == 0);
            tick();
            key_init_in = 1'b0;
            if (ct_out !== ct0 || ct_valid_out !== 1'b1 || pt_ready_out !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold"}, 128'(bad), 128'(0));
        ct_ready_in = 1'b1;
        tick();
        ct_ready_in = 1'b0;
        chk({tag, "_ack"}, 128'(ct_valid_out), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ct_valid"}, 128'(ct_valid_out), 128'(0));
        chk({tag, "_ct"}, ct_out, 128'h0);
        chk({tag, "_rd"}, 128'(round_rd_out), 128'(0));
        chk({tag, "_ready"}, 128'(pt_ready_out), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad, ok;
        int n;
        rst_in = 1'b1; key_init_in = 1'b0; key_expanded_in = 1'b0;
        pt_in = '0; pt_valid_in = 1'b0; ct_ready_in = 1'b0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_in = 1'b0;
        tick();

        // No key yet: requests must be ignored.
        pt_in = rnd128(); pt_valid_in = 1'b1; bad = 1'b0;
        repeat (20) begin
            tick();
            if (pt_ready_out || ct_valid_out) bad = 1'b1;
        end
        pt_valid_in = 1'b0;
        chk("nokey_idle", 128'(bad), 128'(0));

        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_block(128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0, "kat1");
        chk("kat1_fips", ct_out, 128'h3925841d02dc09fbdc118597196a0b32);

        load_key(128'h000102030405060708090a0b0c0d0e0f);
        run_block(128'h00112233445566778899aabbccddeeff, 5, 1'b0, "kat2");
        chk("kat2_fips", ct_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("next_ready", 128'(pt_ready_out), 128'(1));
        run_block(rnd128(), 0, 1'b0, "next_blk");

        // Abort at round 5 via key_init_in, then rekey.
        send(rnd128(), "abort", ok);
        n = 0;
        while (round_rd_out != 4'd5 && n < 30) begin tick(); n++; end
        chk("abort_reach", 128'(round_rd_out), 128'(5));
        key_init_in = 1'b1;
        expand_key(rnd128());
        tick();
        key_init_in = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            if (ct_valid_out || pt_ready_out || round_rd_out != 4'd0) bad = 1'b1;
            tick();
        end
        chk("abort_quiet", 128'(bad), 128'(0));
        key_expanded_in = 1'b1;
        tick();
        key_expanded_in = 1'b0;
        run_block(rnd128(), $urandom_range(0, 3), 1'b0, "after_abort");

        for (int k = 0; k < 4; k++) begin
            load_key(rnd128());
            run_block(rnd128(), $urandom_range(0, 3), 1'b0, "rand_a");
            run_block(rnd128(), $urandom_range(0, 3), 1'b0, "rand_b");
        end

        // key_init_in while the ciphertext waits: it is still delivered.
        load_key(rnd128());
        run_block(rnd128(), 2, 1'b1, "kinit_done");
        chk("kinit_done_ready", 128'(pt_ready_out), 128'(0));

        // Reset in the middle of a block.
        load_key(rnd128());
        send(rnd128(), "rst_mid", ok);
        n = 0;
        while (round_rd_out != 4'd4 && n < 30) begin tick(); n++; end
        rst_in = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
`ifdef AES_BLOCK_COUNT_EN
        chk("rst_mid_count", 128'(blk_count_out), 128'(0));
`endif
        rst_in = 1'b0;
        tick();

        load_key(rnd128());
        ct_ready_in = 1'b0;
        for (int b = 0; b < 3; b++) run_block(rnd128(), 0, 1'b0, "b2b");
`ifdef AES_BLOCK_COUNT_EN
        chk("blk_count", 128'(blk_count_out), 128'(3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
